// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory-access stage and the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_width;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_width,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_width,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory: one outstanding load/store, byte-lane writes,
// sign/zero-extended reads, and a pipeline stall while the access is in flight.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;

    logic             lat_write;
    logic [IDX_W+1:0] lat_addr;
    logic [31:0]      lat_wdata;
    logic [2:0]       lat_width;

    logic             cur_write;
    logic [IDX_W+1:0] cur_addr;
    logic [31:0]      cur_wdata;
    logic [2:0]       cur_width;
    logic [IDX_W-1:0] cur_idx;
    logic             cur_err;
    logic [3:0]       cur_be;
    logic [31:0]      cur_wdata_rep;
    logic             commit;
    logic             mem_we;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      rdata_p1;
    logic             err_p1;

    function automatic logic access_err(input logic write, input logic [2:0] width,
                                        input logic [1:0] lane);
        case (width)
            3'b000:  return 1'b0;
            3'b001:  return lane[0];
            3'b010:  return lane != 2'b00;
            3'b100:  return write;
            3'b101:  return write | lane[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] width, input logic [1:0] lane);
        case (width)
            3'b000:  return 4'b0001 << lane;
            3'b001:  return lane[1] ? 4'b1100 : 4'b0011;
            3'b010:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] width, input logic [31:0] wdata);
        case (width)
            3'b000:  return {4{wdata[7:0]}};
            3'b001:  return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic signed [31:0] load_extend(input logic [31:0] word,
                                                       input logic [2:0] width,
                                                       input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (width)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    // With LATENCY==1 the commit happens on the accepting edge, so the live request is used in IDLE.
    always_comb begin
        cur_write     = (state == IDLE) ? bus.req_write            : lat_write;
        cur_addr      = (state == IDLE) ? bus.req_addr[IDX_W+1:0]  : lat_addr;
        cur_wdata     = (state == IDLE) ? bus.req_wdata            : lat_wdata;
        cur_width     = (state == IDLE) ? bus.req_width            : lat_width;
        cur_idx       = cur_addr[IDX_W+1:2];
        cur_err       = access_err(cur_write, cur_width, cur_addr[1:0]);
        cur_be        = byte_en(cur_width, cur_addr[1:0]);
        cur_wdata_rep = replicate(cur_width, cur_wdata);
        commit        = (state != RESP) && (next_state == RESP);
        mem_we        = commit && reset && cur_write && !cur_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.req_valid) next_state = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
        bus.resp_rdata = rdata_p1;
        bus.resp_err   = err_p1;
        bus.stall      = reset && (((state == IDLE) && bus.req_valid) || (state == WAIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              cnt <= '0;
        else if (state == IDLE && bus.req_valid) cnt <= CNT_W'(LATENCY - 1);
        else if (state == WAIT)                  cnt <= cnt - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr[IDX_W+1:0];
            lat_wdata <= bus.req_wdata;
            lat_width <= bus.req_width;
        end
    end

    // Commit / read stage: the edge entering RESP updates the array and the response register.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else if (commit) begin
            err_p1   <= cur_err;
            rdata_p1 <= (!cur_write && !cur_err) ? load_extend(mem[cur_idx], cur_width, cur_addr[1:0])
                                                 : '0;
        end else begin
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 / depth 1024 and LATENCY 1 / depth 16)
// compared every cycle against a transaction-level memory model.
module tb_dmem_responder;
    localparam int LAT0 = 2;
    localparam int DEP0 = 1024;
    localparam int LAT1 = 1;
    localparam int DEP1 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        rv[2], rw[2];
    logic [31:0] ra[2], rwd[2];
    logic [2:0]  rwid[2];
    logic        rdy[2], vld[2], er[2], stl[2];
    logic [31:0] rd[2];

    int checks = 0;
    int failures = 0;

    dmem_responder_if bus0();
    dmem_responder_if bus1();

    assign bus0.req_valid = rv[0];
    assign bus0.req_write = rw[0];
    assign bus0.req_addr  = ra[0];
    assign bus0.req_wdata = rwd[0];
    assign bus0.req_width = rwid[0];
    assign rdy[0] = bus0.req_ready;
    assign vld[0] = bus0.resp_valid;
    assign rd[0]  = bus0.resp_rdata;
    assign er[0]  = bus0.resp_err;
    assign stl[0] = bus0.stall;

    assign bus1.req_valid = rv[1];
    assign bus1.req_write = rw[1];
    assign bus1.req_addr  = ra[1];
    assign bus1.req_wdata = rwd[1];
    assign bus1.req_width = rwid[1];
    assign rdy[1] = bus1.req_ready;
    assign vld[1] = bus1.resp_valid;
    assign rd[1]  = bus1.resp_rdata;
    assign er[1]  = bus1.resp_err;
    assign stl[1] = bus1.stall;

    dmem_responder #(.DEPTH_WORDS(DEP0), .LATENCY(LAT0)) dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
    dmem_responder #(.DEPTH_WORDS(DEP1), .LATENCY(LAT1)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, d, $time, act, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int dep_of(input int d);
        return (d == 0) ? DEP0 : DEP1;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] mm [int];
    int          since[2] = '{0, 0};
    logic        p_write[2];
    logic [31:0] p_addr[2], p_wdata[2];
    logic [2:0]  p_width[2];
    logic [31:0] exp_rdata[2];
    logic        exp_err[2];

    function automatic logic m_err(input logic w, input logic [2:0] wid, input logic [31:0] a);
        case (wid)
            3'b000:  return 1'b0;
            3'b001:  return a[0];
            3'b010:  return (a % 4) != 0;
            3'b100:  return w;
            3'b101:  return w || a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] wid, input int lane);
        logic [31:0] b, h;
        b = (word >> (8 * lane)) & 32'hFF;
        h = (word >> (8 * lane)) & 32'hFFFF;
        case (wid)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [2:0] wid, input int lane);
        logic [31:0] mask, data;
        case (wid)
            3'b000:  begin mask = 32'hFF << (8 * lane);   data = (wd & 32'hFF) << (8 * lane); end
            3'b001:  begin mask = 32'hFFFF << (8 * lane); data = (wd & 32'hFFFF) << (8 * lane); end
            default: begin mask = 32'hFFFF_FFFF;          data = wd; end
        endcase
        return (old & ~mask) | data;
    endfunction

    task automatic model_commit(input int d);
        int unsigned idx;
        int key;
        int lane;
        idx  = (p_addr[d] >> 2) % dep_of(d);
        key  = d * 100000 + int'(idx);
        lane = int'(p_addr[d] % 4);
        exp_rdata[d] = 32'h0;
        exp_err[d]   = m_err(p_write[d], p_width[d], p_addr[d]);
        if (!exp_err[d]) begin
            if (p_write[d]) mm[key] = m_store(mm.exists(key) ? mm[key] : 32'h0, p_wdata[d], p_width[d], lane);
            else            exp_rdata[d] = m_load(mm.exists(key) ? mm[key] : 32'h0, p_width[d], lane);
        end
    endtask

    // since = cycles elapsed after the accepting edge; the response shows in cycle LATENCY.
    always @(posedge clk or negedge rst_n) begin
        int prev;
        for (int d = 0; d < 2; d++) begin
            prev = since[d];
            if (!rst_n) since[d] = 0;
            else begin
                if (since[d] == lat_of(d)) since[d] = 0;
                else if (since[d] > 0)     since[d] = since[d] + 1;
                else if (rv[d]) begin
                    since[d]   = 1;
                    p_write[d] = rw[d];
                    p_addr[d]  = ra[d];
                    p_wdata[d] = rwd[d];
                    p_width[d] = rwid[d];
                end
                if (since[d] == lat_of(d) && prev != since[d]) model_commit(d);
            end
        end
    end

    always @(negedge clk) begin
        logic e_vld, e_stl;
        for (int d = 0; d < 2; d++) begin
            e_vld = (since[d] == lat_of(d));
            e_stl = rst_n && ((since[d] == 0 && rv[d]) || (since[d] > 0 && since[d] < lat_of(d)));
            chk("req_ready",  d, rdy[d], since[d] == 0);
            chk("resp_valid", d, vld[d], e_vld);
            chk("resp_rdata", d, rd[d],  e_vld ? exp_rdata[d] : 32'h0);
            chk("resp_err",   d, er[d],  e_vld ? exp_err[d] : 1'b0);
            chk("stall",      d, stl[d], e_stl);
        end
    end

    // ---------------- stimulus ----------------
    logic st_acc, st_wait, st_resp;

    task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] wid, output logic [31:0] rdata, output logic rerr);
        bit acc = 0;
        bit got = 0;
        int seen = 0;
        rdata = 32'hx;
        rerr  = 1'bx;
        rv[d] = 1'b1; rw[d] = w; ra[d] = a; rwd[d] = wd; rwid[d] = wid;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rdy[d]) begin acc = 1; st_acc = stl[d]; end
            @(posedge clk); #1;
            if (acc) break;
        end
        rv[d] = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL accept_timeout dut%0d actual=no-accept required=accept", d);
            return;
        end
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (vld[d]) begin
                got = 1; seen = n; rdata = rd[d]; rerr = er[d]; st_resp = stl[d];
                break;
            end
            if (n == 1) st_wait = stl[d];
        end
        chk("latency", d, seen, lat_of(d));
        if (got) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          acc_cnt, resp_cnt;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 0; rw[d] = 0; ra[d] = 0; rwd[d] = 0; rwid[d] = 0;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 0, rdy[0], 1'b1);
        chk("rst_valid", 0, vld[0], 1'b0);
        chk("rst_rdata", 0, rd[0], 32'h0);
        chk("rst_stall", 0, stl[0], 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i <= 16; i++) do_req(0, 1, i * 4, 32'h0, 3'b010, r, e);
        for (int i = 0; i < DEP1; i++) do_req(1, 1, i * 4, 32'h0, 3'b010, r, e);

        do_req(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, r, e);
        do_req(0, 0, 32'h10, 32'h0, 3'b010, r, e);
        chk("lw_10", 0, r, 32'hDEADBEEF);
        chk("stall_accept", 0, st_acc, 1'b1);
        chk("stall_wait", 0, st_wait, 1'b1);
        chk("stall_resp", 0, st_resp, 1'b0);

        do_req(0, 1, 32'h10, 32'h11223344, 3'b010, r, e);
        do_req(0, 1, 32'h13, 32'h000000A5, 3'b000, r, e);
        do_req(0, 0, 32'h10, 32'h0, 3'b010, r, e);  chk("lw_after_sb", 0, r, 32'hA5223344);
        do_req(0, 0, 32'h13, 32'h0, 3'b000, r, e);  chk("lb_13", 0, r, 32'hFFFFFFA5);
        do_req(0, 0, 32'h13, 32'h0, 3'b100, r, e);  chk("lbu_13", 0, r, 32'h000000A5);

        do_req(0, 1, 32'h22, 32'h8001, 3'b001, r, e);
        do_req(0, 0, 32'h22, 32'h0, 3'b001, r, e);  chk("lh_22", 0, r, 32'hFFFF8001);
        do_req(0, 0, 32'h22, 32'h0, 3'b101, r, e);  chk("lhu_22", 0, r, 32'h00008001);
        do_req(0, 0, 32'h21, 32'h0, 3'b001, r, e);
        chk("lh_21_err", 0, e, 1'b1);
        chk("lh_21_rdata", 0, r, 32'h0);
        do_req(0, 0, 32'h20, 32'h0, 3'b010, r, e);  chk("lw_20", 0, r, 32'h80010000);

        do_req(0, 1, 32'h1000, 32'h5, 3'b010, r, e);
        do_req(0, 0, 32'h0, 32'h0, 3'b010, r, e);   chk("wrap_lw_0", 0, r, 32'h5);
        do_req(0, 1, 32'h30, 32'h99, 3'b100, r, e); chk("sbu_err", 0, e, 1'b1);
        do_req(0, 0, 32'h30, 32'h0, 3'b010, r, e);  chk("sbu_nowrite", 0, r, 32'h0);

        // Reset while the store to 0x40 sits in WAIT.
        rv[0] = 1; rw[0] = 1; ra[0] = 32'h40; rwd[0] = 32'h77; rwid[0] = 3'b010;
        @(posedge clk); #1 rv[0] = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 0, rdy[0], 1'b1);
        chk("midrst_valid", 0, vld[0], 1'b0);
        chk("midrst_stall", 0, stl[0], 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_req(0, 0, 32'h40, 32'h0, 3'b010, r, e);  chk("lw_40_after_rst", 0, r, 32'h0);

        // LATENCY=1: valid held high accepts every other cycle.
        acc_cnt = 0; resp_cnt = 0;
        rv[1] = 1; rw[1] = 0; ra[1] = 32'h4; rwid[1] = 3'b010;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rdy[1] && rv[1]) acc_cnt++;
            if (vld[1]) resp_cnt++;
        end
        @(posedge clk); #1 rv[1] = 0;
        chk("b2b_accepts", 1, acc_cnt, 10);
        chk("b2b_resps", 1, resp_cnt, 10);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                do_req(d, 1'($urandom_range(0, 1)), ($urandom << 12) | $urandom_range(0, 63),
                       $urandom, 3'($urandom_range(0, 7)), r, e);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
